// File: rtl/trigger_unit.sv
// Logic-analyser trigger: level match with optional edge match, post-match delay, fire/hold.
// Define TRIGGER_EDGE_EN to build in the rise/fall edge qualifier.
module trigger_unit #(
  parameter int WIDTH   = 8,
  parameter int DELAY_W = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   sample_in,
  input  logic               sample_valid,
  input  logic               arm,
  input  logic               disarm,
  input  logic [WIDTH-1:0]   trig_value,
  input  logic [WIDTH-1:0]   trig_mask,
  input  logic [WIDTH-1:0]   trig_rise,
  input  logic [WIDTH-1:0]   trig_fall,
  input  logic [DELAY_W-1:0] trig_delay,
  output logic               armed,
  output logic               trig_pulse,
  output logic               capture_run,
  output logic [31:0]        trig_index
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_DELAY,
    ST_FIRED
  } state_t;

  state_t             state_reg;
  logic [31:0]        index_reg;
  logic [DELAY_W-1:0] count_reg;
  logic               level_term;
  logic               edge_term;
  logic               match;

  assign level_term = ((sample_in ^ trig_value) & trig_mask) == '0;

`ifdef TRIGGER_EDGE_EN
  logic [WIDTH-1:0] prev_reg;
  logic             prev_valid_reg;
  logic [WIDTH-1:0] edge_ok;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_edge
      assign edge_ok[gi] = (~trig_rise[gi] | (~prev_reg[gi] &  sample_in[gi])) &
                           (~trig_fall[gi] | ( prev_reg[gi] & ~sample_in[gi]));
    end
  endgenerate

  // Without a previous sample no edge can be proven, so only an empty edge request passes.
  assign edge_term = prev_valid_reg ? (&edge_ok) : ~(|{trig_rise, trig_fall});

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      prev_reg       <= '0;
      prev_valid_reg <= 1'b0;
    end else if (state_reg == ST_IDLE && arm && !disarm) begin
      prev_valid_reg <= 1'b0;
    end else if (state_reg == ST_ARMED && sample_valid && !disarm) begin
      prev_reg       <= sample_in;
      prev_valid_reg <= 1'b1;
    end
  end
`else
  logic unused_edge;
  assign unused_edge = ^{trig_rise, trig_fall};
  assign edge_term   = 1'b1;
`endif

  assign match = sample_valid & level_term & edge_term;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg   <= ST_IDLE;
      index_reg   <= '0;
      count_reg   <= '0;
      armed       <= 1'b0;
      trig_pulse  <= 1'b0;
      capture_run <= 1'b0;
      trig_index  <= '0;
    end else begin
      trig_pulse <= 1'b0;
      if (disarm) begin
        state_reg   <= ST_IDLE;
        armed       <= 1'b0;
        capture_run <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (arm) begin
              state_reg <= ST_ARMED;
              armed     <= 1'b1;
              index_reg <= '0;
            end
          end
          ST_ARMED: begin
            if (sample_valid) begin
              if (index_reg != 32'hFFFF_FFFF) begin
                index_reg <= index_reg + 32'd1;
              end
              if (match) begin
                trig_index <= index_reg;
                if (trig_delay == '0) begin
                  state_reg   <= ST_FIRED;
                  armed       <= 1'b0;
                  capture_run <= 1'b1;
                  trig_pulse  <= 1'b1;
                end else begin
                  count_reg <= trig_delay;
                  state_reg <= ST_DELAY;
                end
              end
            end
          end
          ST_DELAY: begin
            if (sample_valid) begin
              count_reg <= count_reg - DELAY_W'(1);
              if (count_reg == DELAY_W'(1)) begin
                state_reg   <= ST_FIRED;
                armed       <= 1'b0;
                capture_run <= 1'b1;
                trig_pulse  <= 1'b1;
              end
            end
          end
          ST_FIRED: begin
          end
          default: begin
            state_reg   <= ST_IDLE;
            armed       <= 1'b0;
            capture_run <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trigger_unit.sv
// Scoreboard bench for trigger_unit: a sequence-level model predicts pulse edge and index,
// a monitor pops and compares on every trig_pulse.
module tb_trigger_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        arm = 1'b0;
  logic        disarm = 1'b0;
  logic [7:0]  trig_value = '0;
  logic [7:0]  trig_mask = '0;
  logic [7:0]  trig_rise = '0;
  logic [7:0]  trig_fall = '0;
  logic [15:0] trig_delay = '0;
  logic        armed;
  logic        trig_pulse;
  logic        capture_run;
  logic [31:0] trig_index;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int          edge_no;
    logic [31:0] idx;
  } exp_t;
  exp_t exp_q[$];

  logic       s_v   [64];
  logic [7:0] s_d   [64];
  logic       s_arm [64];
  logic       s_dis [64];
  int         s_n;

  trigger_unit #(.WIDTH(8), .DELAY_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .arm(arm), .disarm(disarm), .trig_value(trig_value), .trig_mask(trig_mask),
    .trig_rise(trig_rise), .trig_fall(trig_fall), .trig_delay(trig_delay),
    .armed(armed), .trig_pulse(trig_pulse), .capture_run(capture_run), .trig_index(trig_index)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog timeout at edge %0d", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every pulse must correspond to a predicted trigger.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (trig_pulse === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse edge=%0d actual trig_index=%0d required no pulse", cyc, trig_index);
      end else begin
        e = exp_q.pop_front();
        $display("pulse edge=%0d trig_index=%0d", cyc, trig_index);
        check("pulse_edge", cyc, e.edge_no);
        check("trig_index", trig_index, e.idx);
        check("capture_run_at_pulse", capture_run, 1);
      end
    end
  end

  task automatic apply(input bit a, input bit dz, input bit v, input logic [7:0] d);
    arm = a;
    disarm = dz;
    sample_valid = v;
    sample_in = d;
  endtask

  function automatic bit model_match(input logic [7:0] d, input logic [7:0] p, input bit pv);
    bit edg;
    edg = 1'b1;
`ifdef TRIGGER_EDGE_EN
    for (int b = 0; b < 8; b++) begin
      if (trig_rise[b] && !(pv && !p[b] && d[b])) edg = 1'b0;
      if (trig_fall[b] && !(pv && p[b] && !d[b])) edg = 1'b0;
    end
`else
    if (pv && (p != d)) edg = 1'b1;
`endif
    return (((d ^ trig_value) & trig_mask) == 8'h00) && edg;
  endfunction

  function automatic bit exp_armed(input int e, input int fe, input int de);
    return (fe < 0 || e < fe) && (de < 0 || e < de);
  endfunction

  function automatic bit exp_cap(input int e, input int fe, input int de);
    return (fe >= 0 && e >= fe) && (de < 0 || e < de);
  endfunction

  task automatic run_seq(input string tag);
    int e0, fire_edge, dis_edge, idx, remain, mi;
    bit matched, pv;
    logic [7:0] prev;
    exp_t item;
    @(negedge clock);
    e0 = cyc + 1;
    fire_edge = -1; dis_edge = -1; idx = 0; remain = 0; mi = 0;
    matched = 0; pv = 0; prev = '0;
    for (int i = 0; i < s_n; i++) begin
      if (s_dis[i]) begin
        dis_edge = e0 + 1 + i;
        break;
      end
      if (fire_edge >= 0 || !s_v[i]) continue;
      if (!matched) begin
        if (model_match(s_d[i], prev, pv)) begin
          matched = 1;
          mi = idx;
          remain = int'(trig_delay);
          if (remain == 0) fire_edge = e0 + 1 + i;
        end
        idx++;
        prev = s_d[i];
        pv = 1;
      end else begin
        remain--;
        if (remain == 0) fire_edge = e0 + 1 + i;
      end
    end
    if (fire_edge >= 0) begin
      item.edge_no = fire_edge;
      item.idx = mi;
      exp_q.push_back(item);
    end
    $display("run %s: n=%0d val=%h mask=%h rise=%h fall=%h delay=%0d fire_edge=%0d idx=%0d dis_edge=%0d",
             tag, s_n, trig_value, trig_mask, trig_rise, trig_fall, trig_delay, fire_edge - e0, mi, dis_edge - e0);
    apply(1, 0, 0, 8'($urandom));
    for (int i = 0; i < s_n; i++) begin
      @(negedge clock);
      check("armed_step", armed, exp_armed(e0 + i, fire_edge, dis_edge));
      check("capture_run_step", capture_run, exp_cap(e0 + i, fire_edge, dis_edge));
      apply(s_arm[i], s_dis[i], s_v[i], s_d[i]);
    end
    @(negedge clock);
    check("armed_end", armed, exp_armed(e0 + s_n, fire_edge, dis_edge));
    apply(0, 0, 0, 8'h00);
    @(negedge clock);
    check("capture_run_end", capture_run, exp_cap(e0 + s_n + 1, fire_edge, dis_edge));
    check("pulse_queue_drained", exp_q.size(), 0);
    if (fire_edge >= 0) check("trig_index_held", trig_index, mi);
    apply(0, 1, 0, 8'h00);
    @(negedge clock);
    check("armed_after_disarm", armed, 0);
    check("capture_run_after_disarm", capture_run, 0);
    apply(0, 0, 0, 8'h00);
    exp_q.delete();
  endtask

  task automatic clear_seq();
    for (int i = 0; i < 64; i++) begin
      s_v[i] = 0; s_d[i] = '0; s_arm[i] = 0; s_dis[i] = 0;
    end
    s_n = 0;
  endtask

  task automatic push_sample(input bit v, input logic [7:0] d, input bit dz);
    s_v[s_n] = v; s_d[s_n] = d; s_dis[s_n] = dz; s_arm[s_n] = 0;
    s_n++;
  endtask

  task automatic set_cfg(input logic [7:0] v, input logic [7:0] m, input logic [7:0] r,
                         input logic [7:0] f, input logic [15:0] dl);
    trig_value = v; trig_mask = m; trig_rise = r; trig_fall = f; trig_delay = dl;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    check("reset_armed", armed, 0);
    check("reset_trig_pulse", trig_pulse, 0);
    check("reset_capture_run", capture_run, 0);
    check("reset_trig_index", trig_index, 0);

    set_cfg(8'hA5, 8'hFF, 8'h00, 8'h00, 16'd0);
    clear_seq();
    push_sample(1, 8'h00, 0); push_sample(1, 8'h11, 0); push_sample(1, 8'hA5, 0);
    run_seq("level_delay0");

    set_cfg(8'h05, 8'h0F, 8'h00, 8'h00, 16'd3);
    clear_seq();
    push_sample(1, 8'h35, 0); push_sample(1, 8'h12, 0); push_sample(0, 8'h77, 0);
    push_sample(1, 8'h05, 0); push_sample(1, 8'h99, 0);
    run_seq("delay3");

    // arm together with disarm from IDLE must not arm
    set_cfg(8'h00, 8'h00, 8'h00, 8'h00, 16'd0);
    @(negedge clock); apply(1, 1, 0, 8'h00);
    @(negedge clock); apply(0, 0, 1, 8'h00);
    @(negedge clock); apply(0, 0, 0, 8'h00);
    check("arm_disarm_idle_armed", armed, 0);
    check("arm_disarm_idle_capture", capture_run, 0);

    set_cfg(8'h3C, 8'hFF, 8'h00, 8'h00, 16'd0);
    clear_seq();
    push_sample(1, 8'h00, 0); push_sample(1, 8'h3C, 1);
    run_seq("disarm_on_match");

    // reset while in DELAY aborts without a pulse
    set_cfg(8'h42, 8'hFF, 8'h00, 8'h00, 16'd5);
    @(negedge clock); apply(1, 0, 0, 8'h00);
    @(negedge clock); apply(0, 0, 1, 8'h00);
    @(negedge clock); apply(0, 0, 1, 8'h42);
    @(negedge clock); apply(0, 0, 1, 8'h11);
    @(negedge clock); apply(0, 0, 0, 8'h00);
    check("delay_armed_before_reset", armed, 1);
    check("delay_index_before_reset", trig_index, 1);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    check("midreset_armed", armed, 0);
    check("midreset_trig_pulse", trig_pulse, 0);
    check("midreset_capture_run", capture_run, 0);
    check("midreset_trig_index", trig_index, 0);
    set_cfg(8'h42, 8'hFF, 8'h00, 8'h00, 16'd1);
    clear_seq();
    push_sample(1, 8'h13, 0); push_sample(1, 8'h42, 0); push_sample(1, 8'h00, 0);
    run_seq("rerun_after_reset");

`ifdef TRIGGER_EDGE_EN
    set_cfg(8'h00, 8'h00, 8'h01, 8'h00, 16'd0);
    clear_seq();
    push_sample(1, 8'h01, 0); push_sample(1, 8'h00, 0); push_sample(1, 8'h01, 0);
    run_seq("rise_edge");
`else
    set_cfg(8'h00, 8'h00, 8'hFF, 8'h00, 16'd0);
    clear_seq();
    push_sample(1, 8'h37, 0); push_sample(1, 8'h00, 0);
    run_seq("edge_ignored");
`endif

    for (int r = 0; r < 40; r++) begin
      logic [7:0] rr;
      int k;
      rr = ($urandom_range(0, 2) == 0) ? 8'($urandom & $urandom & $urandom) : 8'h00;
      set_cfg(8'($urandom), 8'($urandom & $urandom), rr,
              ($urandom_range(0, 2) == 0) ? (8'($urandom & $urandom) & ~rr) : 8'h00,
              16'($urandom_range(0, 4)));
      clear_seq();
      s_n = $urandom_range(4, 16);
      for (int i = 0; i < s_n; i++) begin
        s_v[i] = ($urandom_range(0, 3) != 0);
        s_d[i] = 8'($urandom);
        if ($urandom_range(0, 2) == 0) s_d[i] = (trig_value & trig_mask) | (8'($urandom) & ~trig_mask);
        s_arm[i] = ($urandom_range(0, 5) == 0);
      end
      if ($urandom_range(0, 4) == 0) begin
        k = $urandom_range(0, s_n - 1);
        s_dis[k] = 1;
        s_n = k + 1;
      end
      run_seq($sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
